// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared configuration for the byte-wide memory controller.
// Holds the bus widths, the default IO region selector, the FSM state
// encodings and a small helper that decides whether an address hits IO space.
package mem_ctrl_pkg;

  localparam int unsigned ByteBusW    = 8;
  localparam int unsigned MemAddrBusW = 32;

  // Address bits [17:16] equal to this value select the IO region.
  localparam logic [1:0] IoMaskDefault = 2'b11;

  // FSM state encodings (plain constants so older tools can share them).
  localparam logic [1:0] StIdle   = 2'b00;
  localparam logic [1:0] StIssue  = 2'b01;
  localparam logic [1:0] StIowait = 2'b10;
  localparam logic [1:0] StResp   = 2'b11;

  // Which cache owns the latched transaction.
  typedef enum logic {
    OwnDc = 1'b0,
    OwnIc = 1'b1
  } owner_e;

  // True when the region-select bits of an address match the IO selector.
  function automatic logic is_io_sel(input logic [1:0] sel, input logic [1:0] mask);
    return sel == mask;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates single-byte requests from a dcache and an icache onto
// one RAM port. One transaction at a time: IDLE -> ISSUE -> RESP, with an
// IOWAIT detour for IO-region writes while the IO output buffer is full.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   dc_read_i/dc_write_i  dcache byte request (level, held until done)
//   dc_addr_i/dc_w_data_i dcache address and write byte
//   dc_r_data_o/dc_done_o dcache read byte and one-cycle completion pulse
//   ic_read_i/ic_addr_i   icache byte read request and address
//   ic_r_data_o/ic_done_o icache read byte and one-cycle completion pulse
//   mem_din               RAM read data, valid the cycle after mem_a
//   mem_dout/mem_a/mem_wr RAM write data, byte address, write strobe
//   io_buffer_full        IO output buffer full; IO writes wait while set
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_MASK = IoMaskDefault
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // dcache side
  input  logic                   dc_read_i,
  input  logic                   dc_write_i,
  input  logic [MemAddrBusW-1:0] dc_addr_i,
  input  logic [ByteBusW-1:0]    dc_w_data_i,
  output logic [ByteBusW-1:0]    dc_r_data_o,
  output logic                   dc_done_o,
  // icache side
  input  logic                   ic_read_i,
  input  logic [MemAddrBusW-1:0] ic_addr_i,
  output logic [ByteBusW-1:0]    ic_r_data_o,
  output logic                   ic_done_o,
  // RAM side
  input  logic [ByteBusW-1:0]    mem_din,
  output logic [ByteBusW-1:0]    mem_dout,
  output logic [MemAddrBusW-1:0] mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full
);

  logic [1:0]             state_q, state_d;
  owner_e                 owner_q, owner_d;
  logic [MemAddrBusW-1:0] addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [ByteBusW-1:0]    data_q, data_d;
  logic [ByteBusW-1:0]    dc_rdata_q, dc_rdata_d;
  logic [ByteBusW-1:0]    ic_rdata_q, ic_rdata_d;

  logic dc_req;
  logic io_stall;
  logic in_resp;

  assign dc_req  = dc_read_i | dc_write_i;
  assign in_resp = (state_q == StResp);

  // The latched transaction is an IO write that must not reach the bus yet.
  // Also checked in ISSUE so a buffer that fills after latching still holds it.
  assign io_stall = wr_q & is_io_sel(addr_q[17:16], IO_MASK) & io_buffer_full;

  // Next-state and latch logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    data_d     = data_q;
    dc_rdata_d = dc_rdata_q;
    ic_rdata_d = ic_rdata_q;

    case (state_q)
      StIdle: begin
        // Fixed priority: dcache wins; a simultaneous read+write is a write.
        if (dc_req) begin
          owner_d = OwnDc;
          addr_d  = dc_addr_i;
          wr_d    = dc_write_i;
          data_d  = dc_w_data_i;
          if (dc_write_i && is_io_sel(dc_addr_i[17:16], IO_MASK) && io_buffer_full) begin
            state_d = StIowait;
          end else begin
            state_d = StIssue;
          end
        end else if (ic_read_i) begin
          owner_d = OwnIc;
          addr_d  = ic_addr_i;
          wr_d    = 1'b0;
          data_d  = '0;
          state_d = StIssue;
        end
      end

      StIssue: begin
        state_d = io_stall ? StIowait : StResp;
      end

      StIowait: begin
        if (!io_buffer_full) begin
          state_d = StIssue;
        end
      end

      StResp: begin
        // Capture the returned byte so the owner's output holds it afterwards.
        if (owner_q == OwnDc) begin
          dc_rdata_d = mem_din;
        end else begin
          ic_rdata_d = mem_din;
        end
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= OwnDc;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      dc_rdata_q <= '0;
      ic_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      dc_rdata_q <= dc_rdata_d;
      ic_rdata_q <= ic_rdata_d;
    end
  end

  // RAM port: only driven while issuing; zero everywhere else.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if ((state_q == StIssue) && !io_stall) begin
      mem_a    = addr_q;
      mem_dout = data_q;
      mem_wr   = wr_q;
    end
  end

  // Completion and read data. In RESP the owner sees mem_din directly; the
  // capture register supplies the same byte from the next cycle on.
  always_comb begin
    dc_done_o   = in_resp && (owner_q == OwnDc);
    ic_done_o   = in_resp && (owner_q == OwnIc);
    dc_r_data_o = dc_done_o ? mem_din : dc_rdata_q;
    ic_r_data_o = ic_done_o ? mem_din : ic_rdata_q;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A behavioural RAM sits on
// the memory port; a shadow byte map tracks what every address should hold.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dc_read_i = 1'b0;
  logic        dc_write_i = 1'b0;
  logic [31:0] dc_addr_i = '0;
  logic [7:0]  dc_w_data_i = '0;
  logic [7:0]  dc_r_data_o;
  logic        dc_done_o;
  logic        ic_read_i = 1'b0;
  logic [31:0] ic_addr_i = '0;
  logic [7:0]  ic_r_data_o;
  logic        ic_done_o;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int done_cyc = 0;

  logic [7:0] ram    [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];

  mem_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dc_read_i     (dc_read_i),
    .dc_write_i    (dc_write_i),
    .dc_addr_i     (dc_addr_i),
    .dc_w_data_i   (dc_w_data_i),
    .dc_r_data_o   (dc_r_data_o),
    .dc_done_o     (dc_done_o),
    .ic_read_i     (ic_read_i),
    .ic_addr_i     (ic_addr_i),
    .ic_r_data_o   (ic_r_data_o),
    .ic_done_o     (ic_done_o),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM: registered read of the presented address, write on strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expect_byte(input logic [31:0] addr);
    return shadow.exists(addr) ? shadow[addr] : 8'h00;
  endfunction

  // kind: 0 dc read, 1 dc write, 2 ic read, 3 dc read+write (acts as write)
  task automatic drive_req(input int kind, input logic [31:0] addr, input logic [7:0] data,
                           input int n);
    @(negedge clk);
    if (kind == 2) begin
      ic_read_i = 1'b1;
      ic_addr_i = addr;
    end else begin
      dc_read_i   = (kind == 0) || (kind == 3);
      dc_write_i  = (kind == 1) || (kind == 3);
      dc_addr_i   = addr;
      dc_w_data_i = data;
    end
    io_buffer_full = (n > 0);
  endtask

  task automatic drop_req();
    dc_read_i  = 1'b0;
    dc_write_i = 1'b0;
    ic_read_i  = 1'b0;
  endtask

  // Walks the transaction cycle by cycle; the request was driven in an idle cycle.
  task automatic check_txn(input int kind, input logic [31:0] addr, input logic [7:0] data,
                           input int n, input bit drop_early);
    bit   wr;
    bit   is_dc;
    int   exp_done;
    logic own_done;
    logic oth_done;
    logic [7:0] rdata;
    wr    = (kind == 1) || (kind == 3);
    is_dc = (kind != 2);
    // Only IO writes wait for the buffer; one extra cycle per full cycle.
    exp_done = 2 + ((wr && addr[17:16] == 2'b11) ? n : 0);
    for (int k = 1; k <= exp_done; k++) begin
      @(negedge clk);
      own_done = is_dc ? dc_done_o : ic_done_o;
      oth_done = is_dc ? ic_done_o : dc_done_o;
      rdata    = is_dc ? dc_r_data_o : ic_r_data_o;
      chk("owner_done", own_done, (k == exp_done));
      chk("other_done", oth_done, 1'b0);
      if (k == exp_done - 1) begin
        chk("issue_wr", mem_wr, wr);
        chk("issue_addr", mem_a, addr);
        if (wr) chk("issue_dout", mem_dout, data);
      end else begin
        chk("quiet_wr", mem_wr, 1'b0);
        chk("quiet_addr", mem_a, 32'h0);
        chk("quiet_dout", mem_dout, 32'h0);
      end
      if (k == exp_done) begin
        done_cyc = cyc;
        if (!wr) chk("rdata", rdata, expect_byte(addr));
      end
      if (drop_early && k == 1) drop_req();
      if (k == n) io_buffer_full = 1'b0;
    end
    drop_req();
    io_buffer_full = 1'b0;
    if (wr) shadow[addr] = data;
  endtask

  initial begin
    int kind;
    int n;
    int sel;
    int prev;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [31:0] bases [4];
    bases[0] = 32'h0000_0000;
    bases[1] = 32'h0003_0000;
    bases[2] = 32'h0002_0000;
    bases[3] = 32'hFF03_0000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dc_done", dc_done_o, 1'b0);
    chk("rst_ic_done", ic_done_o, 1'b0);
    chk("rst_dc_rdata", dc_r_data_o, 8'h00);
    chk("rst_ic_rdata", ic_r_data_o, 8'h00);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", mem_dout, 8'h00);
    rst_n = 1'b1;

    // Seed RAM through the controller, then basic read and write
    drive_req(1, 32'h100, 8'hA5, 0); check_txn(1, 32'h100, 8'hA5, 0, 1'b0);
    drive_req(0, 32'h100, 8'h00, 0); check_txn(0, 32'h100, 8'h00, 0, 1'b0);
    drive_req(1, 32'h204, 8'h3C, 0); check_txn(1, 32'h204, 8'h3C, 0, 1'b0);

    // Simultaneous dcache and icache reads: dcache first, icache three later
    @(negedge clk);
    dc_read_i = 1'b1; dc_addr_i = 32'h204;
    ic_read_i = 1'b1; ic_addr_i = 32'h100;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("arb_dc_done", dc_done_o, (k == 2));
      chk("arb_ic_done", ic_done_o, (k == 5));
      if (k == 1) chk("arb_addr_dc", mem_a, 32'h204);
      if (k == 4) chk("arb_addr_ic", mem_a, 32'h100);
      if (k == 2) begin
        chk("arb_dc_rdata", dc_r_data_o, 8'h3C);
        dc_read_i = 1'b0;
      end
      if (k == 5) begin
        chk("arb_ic_rdata", ic_r_data_o, 8'hA5);
        ic_read_i = 1'b0;
      end
    end
    @(negedge clk);
    chk("hold_ic_rdata", ic_r_data_o, 8'hA5);
    chk("hold_dc_rdata", dc_r_data_o, 8'h3C);

    // Reset during ISSUE drops the transaction; held request is re-arbitrated
    drive_req(0, 32'h204, 8'h00, 0);
    @(negedge clk);
    chk("pre_rst_addr", mem_a, 32'h204);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_addr", mem_a, 32'h0);
    chk("rst_mid_rdata", dc_r_data_o, 8'h00);
    chk("rst_mid_done", dc_done_o, 1'b0);
    @(negedge clk);
    chk("rst_hold_done", dc_done_o, 1'b0);
    chk("rst_hold_wr", mem_wr, 1'b0);
    rst_n = 1'b1;
    check_txn(0, 32'h204, 8'h00, 0, 1'b0);

    // IO write held off by a full buffer for four cycles
    drive_req(1, 32'h0003_0000, 8'h5A, 4); check_txn(1, 32'h0003_0000, 8'h5A, 4, 1'b0);
    // A single cycle of full still forces a wait
    drive_req(1, 32'h0003_0001, 8'h77, 1); check_txn(1, 32'h0003_0001, 8'h77, 1, 1'b0);
    // Full buffer does not delay a non-IO write
    drive_req(1, 32'h0002_0004, 8'h11, 3); check_txn(1, 32'h0002_0004, 8'h11, 3, 1'b0);

    // Block fill: write 0x10..0x13, then four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive_req(1, 32'h10 + i, 8'hC0 + i[7:0], 0);
      check_txn(1, 32'h10 + i, 8'hC0 + i[7:0], 0, 1'b0);
    end
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      drive_req(0, 32'h10 + i, 8'h00, 0);
      check_txn(0, 32'h10 + i, 8'h00, 0, 1'b0);
      if (i > 0) chk("fill_spacing", done_cyc - prev, 3);
      prev = done_cyc;
    end

    // Requests dropped right after being latched still complete
    drive_req(0, 32'h11, 8'h00, 0); check_txn(0, 32'h11, 8'h00, 0, 1'b1);
    drive_req(2, 32'h12, 8'h00, 0); check_txn(2, 32'h12, 8'h00, 0, 1'b1);
    drive_req(3, 32'h13, 8'h9E, 0); check_txn(3, 32'h13, 8'h9E, 0, 1'b0);

    // Randomised traffic against the shadow map
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 3);
      sel  = $urandom_range(0, 3);
      addr = bases[sel] | 32'($urandom_range(0, 7));
      data = 8'($urandom);
      n    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drive_req(kind, addr, data, n);
      check_txn(kind, addr, data, n, ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter IO_MASK, default 2'b11, meaning address bits [17:16] equal to IO_MASK select the IO region.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 dc_read_i  in  1  dcache byte read request, level, held until done.
REQ-005 dc_write_i  in  1  dcache byte write request, level, held until done.
REQ-006 dc_addr_i  in  32  dcache byte address.
REQ-007 dc_w_data_i  in  8  dcache write byte.
REQ-008 dc_r_data_o  out  8  dcache read byte, valid when dc_done_o=1.
REQ-009 dc_done_o  out  1  one-cycle completion pulse to dcache.
REQ-010 ic_read_i  in  1  icache byte read request, level, held until done.
REQ-011 ic_addr_i  in  32  icache byte address.
REQ-012 ic_r_data_o  out  8  icache read byte, valid when ic_done_o=1.
REQ-013 ic_done_o  out  1  one-cycle completion pulse to icache.
REQ-014 mem_din  in  8  RAM read data, valid one cycle after mem_a is presented.
REQ-015 mem_dout  out  8  RAM write data.
REQ-016 mem_a  out  32  RAM byte address.
REQ-017 mem_wr  out  1  RAM write strobe, 1=write.
REQ-018 io_buffer_full  in  1  IO output buffer full; IO writes must not issue while 1.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, IOWAIT, RESP; one byte per transaction.
REQ-020 IDLE: if dc_read_i or dc_write_i, latch owner=DC, addr, write flag, data -> ISSUE; else if ic_read_i, latch owner=IC -> ISSUE; else stay.
REQ-021 Arbitration SHALL be fixed priority dcache over icache, evaluated only in IDLE; no preemption of a latched transaction.
REQ-022 dc_read_i and dc_write_i both 1 SHALL be treated as write.
REQ-023 ISSUE: mem_a=latched addr, mem_dout=latched data, mem_wr=latched write flag; next state RESP.
REQ-024 Latched IO write (addr[17:16]==IO_MASK) with io_buffer_full=1 on entry SHALL go to IOWAIT instead of issuing: mem_wr=0, mem_a=0; leave to ISSUE the cycle after io_buffer_full=0.
REQ-025 RESP: assert owner's done for exactly this cycle; owner's r_data output = mem_din (capture register, held until next RESP of same owner); mem_wr=0; next state IDLE.
REQ-026 Latency: request seen in IDLE at cycle T -> done at T+2 (no IO stall); back-to-back requests complete every 3 cycles.
REQ-027 Requester dropping its request after latch SHALL NOT abort; transaction completes, done still pulses.
REQ-028 In IDLE, IOWAIT, RESP: mem_wr=0, mem_a=0, mem_dout=0.
REQ-029 Non-owner done output SHALL remain 0 throughout a transaction.
REQ-030 Address passes unmodified (32 bits); no alignment or range checks.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, all done outputs 0, r_data outputs 8'h00, mem_wr 0, mem_a 0, mem_dout 0, latched registers cleared.
REQ-032 Reset asserted mid-transaction SHALL discard it with no done pulse; after release, a still-held request is re-arbitrated from IDLE.

Structure
REQ-033 FSM state encodings, IO_MASK default, and ByteBus/MemAddrBus widths SHALL live in shared config.v.
REQ-034 Single module; no sub-module required.

Verification
REQ-035 dc read addr 0x100, RAM[0x100]=0xA5 -> mem_a=0x100 mem_wr=0 at T+1, dc_done_o=1, dc_r_data_o=0xA5 at T+2.
REQ-036 dc write addr 0x204 data 0x3C -> mem_wr=1, mem_a=0x204, mem_dout=0x3C for exactly one cycle; dc_done_o at T+2.
REQ-037 dc read and ic read both raised same cycle -> dcache served first (done at T+2), icache done at T+5; ic_done_o never 1 during dcache transaction.
REQ-038 dc write 0x30000 with io_buffer_full=1 for 4 cycles -> mem_wr stays 0 while full, single write one cycle after release, done next cycle.
REQ-039 rst_n low during ISSUE -> outputs zero immediately, no done pulse; after release held request completes in 2 cycles.
REQ-040 4 consecutive dcache reads 0x10..0x13 (dcache-style block fill) -> done pulses at 3-cycle spacing with correct bytes.
